tlc_conflict_monitor: RTL
=========================

Name: tlc_conflict_monitor

Overview:
- Receiving end of the traffic-light controller's signal outputs: watches `highwaySignal` and `farmSignal` every clock.
- Checks encoding, mutual exclusion, sequence order and minimum yellow/clearance timing.
- Latches the first violation with a fault code and forces both safe outputs to red until cleared.
- Sits between the controller and the lamp drivers.

Parameters:
- CNT_W, 31, width of the internal timing counters.
- YELLOW_MIN, 150000000, minimum consecutive yellow cycles before red (3 s at 50 MHz).
- ALLRED_MIN, 50000000, minimum consecutive both-red cycles before either signal turns green (1 s at 50 MHz).

Ports:
- Clk  input  1  system clock, 50 MHz.
- Rst  input  1  synchronous, active-low reset.
- highwaySignal  input  2  monitored highway lamp code.
- farmSignal  input  2  monitored farm lamp code.
- faultClr  input  1  one-cycle request to clear the latched fault.
- fault  output  1  latched fault flag.
- faultCode  output  3  code of the first latched violation; 0 = none.
- safeHighway  output  2  highway code to the lamp driver.
- safeFarm  output  2  farm code to the lamp driver.
- monState  output  1  debug: 0 = ARMED, 1 = FAULTED.

Behaviour:
- Lamp encoding: red = 2'b00, yellow = 2'b01, green = 2'b11. 2'b10 is illegal.
- Reset (Rst == 0 at posedge Clk):
  - fault = 0, faultCode = 0, monState = ARMED.
  - safeHighway = safeFarm = red.
  - Previous-sample registers = red/red.
  - Yellow counters and all-red counter = 0.
- All checks compare the current inputs against the previous-sample registers. Previous-sample registers load the inputs every cycle, including while FAULTED.
- Fault codes, checked in priority order (the lowest number wins when several occur in the same cycle):
  - 1 = illegal encoding (2'b10) on either input.
  - 2 = conflict: both inputs non-red in the same cycle.
  - 3 = illegal transition on either signal. Legal changes are hold, red->green, green->yellow and yellow->red only.
  - 4 = short yellow: yellow->red while that signal's yellow counter < YELLOW_MIN.
  - 5 = short clearance: red->green while the all-red counter < ALLRED_MIN.
- Yellow counters (one per signal):
  - A signal's counter counts consecutive previous-sample cycles in which that signal was yellow; saturates at YELLOW_MIN.
  - Resets to 0 whenever the previous sample for that signal is not yellow.
- All-red counter:
  - Counts consecutive previous-sample cycles in which both signals were red; saturates at ALLRED_MIN.
  - Resets to 0 whenever either signal is non-red.
- Counter widths are CNT_W; saturation prevents wrap-around.
- ARMED -> FAULTED:
  - Triggered by any detection in the cycle where the offending input is presented.
  - At the next posedge: fault = 1, faultCode = detected code, safe outputs = red.
  - Latency is 1 cycle.
- ARMED, no detection: safeHighway/safeFarm take the current inputs at posedge (1-cycle registered pass-through).
- While FAULTED:
  - faultCode holds the first fault; later detections do not overwrite it.
  - Safe outputs stay red.
  - Checks and counters keep running.
- FAULTED -> ARMED:
  - Occurs on faultClr = 1 with no detection that cycle: fault = 0, faultCode = 0.
  - Safe outputs resume pass-through from the following cycle; they stay red on the clear edge itself.
- faultClr and a detection in the same cycle: the detection wins. fault stays 1 and faultCode is loaded with the new code.
- faultClr while ARMED: no effect.
- Rst low mid-fault or mid-yellow: full reset to the values above. The first green after reset still requires ALLRED_MIN both-red cycles.
- No combinational path from inputs to outputs.

Test Plan:
- Bench runs with YELLOW_MIN = 4 and ALLRED_MIN = 2.
- Legal cycle: red/red ×3 -> highway green ×5 -> yellow ×4 -> red/red ×2 -> farm green -> fault stays 0; safe outputs equal the inputs delayed 1 cycle.
- Conflict: highway green and farm set to green in the same cycle -> next posedge fault = 1, faultCode = 2, safeHighway = safeFarm = 2'b00.
- Short yellow: highway green -> yellow ×2 -> red -> faultCode = 4 one cycle after red is presented. A later farm 2'b10 leaves faultCode at 4.
- Simultaneous: farm = 2'b10 while highway goes green->red in the same cycle -> faultCode = 1 (priority).
- Short clearance: both red 1 cycle then farm green -> faultCode = 5. Then pulse faultClr with legal inputs -> fault = 0, faultCode = 0; pass-through resumes the next cycle.
- Clear vs new fault: assert faultClr in the same cycle as an illegal green->red -> fault stays 1, faultCode = 3. Drop Rst for 1 cycle -> all outputs return to reset values.

Source files
------------

// File: rtl/tlc_conflict_monitor.sv
// Conflict monitor for a two-way traffic-light controller.
// Watches the highway and farm lamp codes every clock and checks four things:
// the encoding, mutual exclusion, the order of the lamp sequence, and the
// minimum yellow and all-red durations. The first violation is latched with a
// fault code, and both safe lamp outputs are forced to red until the fault is
// cleared.
module tlc_conflict_monitor #(
   parameter int unsigned CNT_W      = 31,
   parameter int unsigned YELLOW_MIN = 150000000,
   parameter int unsigned ALLRED_MIN = 50000000
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic [1:0] highwaySignal,
   input  logic [1:0] farmSignal,
   input  logic       faultClr,
   output logic       fault,
   output logic [2:0] faultCode,
   output logic [1:0] safeHighway,
   output logic [1:0] safeFarm,
   output logic       monState
);

   localparam logic [1:0] L_RED = 2'b00;
   localparam logic [1:0] L_YLW = 2'b01;
   localparam logic [1:0] L_BAD = 2'b10;
   localparam logic [1:0] L_GRN = 2'b11;

   localparam logic [CNT_W-1:0] YMIN = CNT_W'(YELLOW_MIN);
   localparam logic [CNT_W-1:0] AMIN = CNT_W'(ALLRED_MIN);

   typedef enum logic {S_ARMED = 1'b0, S_FAULTED = 1'b1} state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic [1:0]       r_prevHw;
   logic [1:0]       r_prevFarm;
   logic [CNT_W-1:0] r_yCntHw;
   logic [CNT_W-1:0] r_yCntFarm;
   logic [CNT_W-1:0] r_arCnt;
   logic [2:0]       r_faultCode;
   logic [1:0]       r_safeHw;
   logic [1:0]       r_safeFarm;
   logic [2:0]       w_code;
   logic             w_det;

   // Only hold, red->green, green->yellow and yellow->red are legal
   function automatic logic f_legal(input logic [1:0] p, input logic [1:0] c);
      return (c == p) ||
             ((p == L_RED) && (c == L_GRN)) ||
             ((p == L_GRN) && (c == L_YLW)) ||
             ((p == L_YLW) && (c == L_RED));
   endfunction

   // The counters track runs of the incoming samples. When a sample becomes
   // the previous sample, its counter already includes that sample. The run
   // length is therefore ready in the same cycle that the transition is checked.
   // Track the previous sample, the yellow run lengths and the all-red run length
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         r_prevHw   <= L_RED;
         r_prevFarm <= L_RED;
         r_yCntHw   <= '0;
         r_yCntFarm <= '0;
         r_arCnt    <= '0;
      end else begin
         r_prevHw   <= highwaySignal;
         r_prevFarm <= farmSignal;
         if (highwaySignal == L_YLW)
            r_yCntHw <= (r_yCntHw < YMIN) ? r_yCntHw + CNT_W'(1) : r_yCntHw;
         else
            r_yCntHw <= '0;
         if (farmSignal == L_YLW)
            r_yCntFarm <= (r_yCntFarm < YMIN) ? r_yCntFarm + CNT_W'(1) : r_yCntFarm;
         else
            r_yCntFarm <= '0;
         if ((highwaySignal == L_RED) && (farmSignal == L_RED))
            r_arCnt <= (r_arCnt < AMIN) ? r_arCnt + CNT_W'(1) : r_arCnt;
         else
            r_arCnt <= '0;
      end
   end

   // Classify the current sample; lower codes take priority
   always_comb begin
      w_code = '0;
      if ((highwaySignal == L_BAD) || (farmSignal == L_BAD))
         w_code = 3'd1;
      else if ((highwaySignal != L_RED) && (farmSignal != L_RED))
         w_code = 3'd2;
      else if (!f_legal(r_prevHw, highwaySignal) || !f_legal(r_prevFarm, farmSignal))
         w_code = 3'd3;
      else if (((r_prevHw == L_YLW) && (highwaySignal == L_RED) && (r_yCntHw < YMIN)) ||
               ((r_prevFarm == L_YLW) && (farmSignal == L_RED) && (r_yCntFarm < YMIN)))
         w_code = 3'd4;
      else if ((((r_prevHw == L_RED) && (highwaySignal == L_GRN)) ||
                ((r_prevFarm == L_RED) && (farmSignal == L_GRN))) && (r_arCnt < AMIN))
         w_code = 3'd5;
   end

   assign w_det = |w_code;

   // Monitor state register
   always_ff @(posedge Clk) begin
      if (!Rst) r_state <= S_ARMED;
      else      r_state <= w_nextState;
   end

   // A clear re-arms only when nothing is detected in the same cycle
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_ARMED:   if (w_det) w_nextState = S_FAULTED;
         S_FAULTED: if (faultClr && !w_det) w_nextState = S_ARMED;
         default:   w_nextState = S_ARMED;
      endcase
   end

   // Fault flags decoded from the registered state
   always_comb begin
      fault    = (r_state == S_FAULTED);
      monState = (r_state == S_FAULTED);
   end

   // Latch the fault code and drive the registered safe lamp outputs
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         r_faultCode <= '0;
         r_safeHw    <= L_RED;
         r_safeFarm  <= L_RED;
      end else begin
         if (w_det && ((r_state == S_ARMED) || faultClr))
            r_faultCode <= w_code;
         else if ((r_state == S_FAULTED) && faultClr)
            r_faultCode <= '0;
         if ((r_state == S_ARMED) && !w_det) begin
            r_safeHw   <= highwaySignal;
            r_safeFarm <= farmSignal;
         end else begin
            r_safeHw   <= L_RED;
            r_safeFarm <= L_RED;
         end
      end
   end

   assign faultCode   = r_faultCode;
   assign safeHighway = r_safeHw;
   assign safeFarm    = r_safeFarm;

endmodule
